hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised issue-stage hazard unit for the dynamic pipeline; generalises the fixed load-use stall check into a per-register countdown scoreboard. Tracks the remaining cycles until each pending destination register becomes forwardable, for ALU, load and multi-cycle mult/div classes. It also covers the mult/div structural hazard and WAW ordering. It sits beside the ID stage; its stall output freezes PC/IF/ID and inserts a bubble into EX.

Parameters:
REG_NUM, 32, number of architectural registers; register 0 is hard-wired zero and never tracked.
ADDR_W, 5, register address width; REG_NUM <= 2**ADDR_W.
LOAD_LAT, 3, stall cycles a dependent instruction sees immediately after a load issues.
MD_LAT, 8, cycles from mult/div issue until its result is readable.
CNT_W, 4, countdown width; must hold max(LOAD_LAT, MD_LAT); elaboration error otherwise.

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  ADDR_W  source register 1
id_rt  in  ADDR_W  source register 2
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_wen  in  1  instruction writes a register
id_waddr  in  ADDR_W  destination register
id_class  in  2  0=ALU, 1=load, 2=mult/div, 3=treated as ALU
flush  in  1  squash ID this cycle (taken branch/jump)
stall  out  1  hold ID; do not issue
md_busy  out  1  mult/div unit occupied
stall_cnt  out  32  total stall cycles (optional feature)
raw_stall_cnt  out  32  stall cycles caused by RAW (optional feature)

Behaviour:
- One clock domain. All state is updated on the rising clk edge. Reset is synchronous and active-high.
- State: cnt[1..REG_NUM-1] (CNT_W each) and md_cnt (CNT_W).
- Reset: all cnt = 0, md_cnt = 0, stall = 0, md_busy = 0, stall_cnt = 0, raw_stall_cnt = 0. Reset asserted mid-operation discards all pending entries on that edge.
- stall is combinational, with zero-cycle latency from the ID inputs. It asserts when id_valid && !flush and any of the following holds:
  - RAW: (id_use_rs && id_rs != 0 && cnt[id_rs] != 0) or (id_use_rt && id_rt != 0 && cnt[id_rt] != 0).
  - Structural: id_class == 2 && md_cnt != 0.
  - WAW: id_wen && id_waddr != 0 && cnt[id_waddr] > lat(id_class), where lat is ALU 0, load LOAD_LAT, mult/div MD_LAT.
- issue = id_valid && !flush && !stall.
- Per edge, for each register r:
  - If issue && id_wen && id_waddr == r && r != 0, then cnt[r] <= lat(id_class). The issue write wins over the decrement, including when lat is 0.
  - Otherwise, if cnt[r] != 0, then cnt[r] <= cnt[r] - 1.
- md_cnt: set to MD_LAT on issue of class 2, otherwise decrement toward 0. md_busy = (md_cnt != 0), registered-derived.
- Timing: load issues at edge t. A dependent instruction in ID stalls during cycles t+1 .. t+LOAD_LAT and issues in cycle t+LOAD_LAT+1. ALU producers never stall consumers; full forwarding is provided.
- flush: forces stall = 0 and suppresses issue in that cycle. Counters keep decrementing, because already-issued older instructions are not squashed.
- id_valid = 0: stall = 0, no issue; counters decrement.
- Writes to register 0 are ignored. Sources equal to 0 never stall.
- Counters saturate at 0 and never wrap.

Optional Feature:
HAZARD_STALL_STAT_EN
- Defined:
  - stall_cnt increments by 1 on every cycle with stall = 1.
  - raw_stall_cnt increments by 1 when the RAW term is true and stall = 1.
  - Both counters wrap modulo 2**32 and reset to 0.
- Undefined: no counter registers are built; both outputs are tied to 0. Ports remain present.

Test Plan:
1. Load-use: lw to $8 issues, then add reading $8 -> stall = 1 for exactly 3 cycles, issues on the 4th; with the feature, stall_cnt = 3 and raw_stall_cnt = 3.
2. ALU chain: add to $5, then sub reading $5 on both rs and rt -> stall never asserts; cnt[5] stays 0.
3. mult/div back-to-back: div issues, next div in ID -> stall = 1 and md_busy = 1 for 8 cycles, then issues. A mfhi-style reader of the dest register also waits 8 cycles.
4. WAW: div writing $9 issues; 2 cycles later an ALU write to $9 -> stall = 1 until cnt[9] = 0 (6 cycles), then issues with cnt[9] = 0.
5. Flush and $0: lw to $3, next instruction reads $3 with flush = 1 -> stall = 0 and no issue. An lw to $0 followed by a reader of $0 -> no stall.
6. Reset mid-op: div in flight (md_cnt = 5) and lw pending on $4; rst = 1 for one cycle -> next cycle md_busy = 0 and a reader of $4 issues with no stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: per-register countdowns for RAW/WAW plus mult/div occupancy.
// Define HAZARD_STALL_STAT_EN to build the stall statistics counters.
module hazard_scoreboard #(
  parameter int unsigned REG_NUM  = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LOAD_LAT = 3,
  parameter int unsigned MD_LAT   = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wen,
  input  logic [ADDR_W-1:0] id_waddr,
  input  logic [1:0]        id_class,
  input  logic              flush,
  output logic              stall,
  output logic              md_busy,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       raw_stall_cnt
);

  localparam int unsigned NumSlots = 2 ** ADDR_W;
  localparam int unsigned MaxLat   = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;

  localparam logic [1:0] ClassLoad = 2'd1;
  localparam logic [1:0] ClassMd   = 2'd2;

  localparam logic [CNT_W-1:0] LoadLatC = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] MdLatC   = CNT_W'(MD_LAT);
  localparam logic [CNT_W-1:0] OneC     = CNT_W'(1);

  if (MaxLat > (2 ** CNT_W) - 1) begin : g_cnt_w_check
    $error("CNT_W cannot hold max(LOAD_LAT, MD_LAT)");
  end
  if (REG_NUM > NumSlots) begin : g_addr_w_check
    $error("REG_NUM exceeds 2**ADDR_W");
  end

  // One slot per encodable address; slot 0 and slots >= REG_NUM stay zero.
  logic [CNT_W-1:0] cnt_q [NumSlots];
  logic [CNT_W-1:0] cnt_d [NumSlots];
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] id_lat;

  logic rs_hit, rt_hit;
  logic raw_hazard, struct_hazard, waw_hazard;
  logic issue;

  always_comb begin
    unique case (id_class)
      ClassLoad: id_lat = LoadLatC;
      ClassMd:   id_lat = MdLatC;
      default:   id_lat = '0;
    endcase
  end

  assign rs_hit        = id_use_rs && (id_rs != '0) && (cnt_q[id_rs] != '0);
  assign rt_hit        = id_use_rt && (id_rt != '0) && (cnt_q[id_rt] != '0);
  assign raw_hazard    = rs_hit || rt_hit;
  assign struct_hazard = (id_class == ClassMd) && (md_cnt_q != '0);
  // A younger writer may not land before an older, slower writer of the same register.
  assign waw_hazard    = id_wen && (id_waddr != '0) && (cnt_q[id_waddr] > id_lat);

  assign stall   = id_valid && !flush && (raw_hazard || struct_hazard || waw_hazard);
  assign issue   = id_valid && !flush && !stall;
  assign md_busy = (md_cnt_q != '0);

  always_comb begin
    for (int unsigned r = 0; r < NumSlots; r++) begin
      cnt_d[r] = '0;
      if ((r != 0) && (r < REG_NUM)) begin
        if (issue && id_wen && (32'(id_waddr) == r)) begin
          cnt_d[r] = id_lat;
        end else if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - OneC;
        end
      end
    end
  end

  always_comb begin
    md_cnt_d = '0;
    if (issue && (id_class == ClassMd)) begin
      md_cnt_d = MdLatC;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - OneC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NumSlots; r++) begin
        cnt_q[r] <= '0;
      end
      md_cnt_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NumSlots; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_STALL_STAT_EN
  logic [31:0] stall_cnt_q, raw_stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q     <= '0;
      raw_stall_cnt_q <= '0;
    end else begin
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (stall && raw_hazard) begin
        raw_stall_cnt_q <= raw_stall_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign raw_stall_cnt = raw_stall_cnt_q;
`else
  assign stall_cnt     = '0;
  assign raw_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, ALU chain, mult/div, WAW, flush, $0, reset.
module tb_hazard_scoreboard;

`ifdef HAZARD_STALL_STAT_EN
  localparam bit StatEn = 1'b1;
`else
  localparam bit StatEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs, id_use_rt, id_wen, flush;
  logic [4:0]  id_rs, id_rt, id_waddr;
  logic [1:0]  id_class;
  logic        stall, md_busy;
  logic [31:0] stall_cnt, raw_stall_cnt;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_wen       (id_wen),
    .id_waddr     (id_waddr),
    .id_class     (id_class),
    .flush        (flush),
    .stall        (stall),
    .md_busy      (md_busy),
    .stall_cnt    (stall_cnt),
    .raw_stall_cnt(raw_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int v);
    return StatEn ? 32'(v) : 32'd0;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wen,
                       input logic [4:0] wa, input logic [1:0] cls, input logic fl);
    id_valid  = v;
    id_rs     = rs;
    id_rt     = rt;
    id_use_rs = urs;
    id_use_rt = urt;
    id_wen    = wen;
    id_waddr  = wa;
    id_class  = cls;
    flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts stall cycles for the instruction held in ID; returns at the negedge where it is free.
  task automatic count_stalls(output int cnt);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!stall) return;
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_md_busy", 32'(md_busy), 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    rst = 1'b0;
    step();

    // Load-use on $8
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 2'd1, 1'b0);
    @(negedge clk);
    check("lw_issue", 32'(stall), 32'd0);
    step();
    drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd10, 2'd0, 1'b0);
    count_stalls(n);
    check("load_use_stalls", 32'(n), 32'd3);
    check("load_use_stall_cnt", stall_cnt, stat(3));
    check("load_use_raw_cnt", raw_stall_cnt, stat(3));
    step();

    // ALU chain through $5
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 2'd0, 1'b0);
    @(negedge clk);
    check("alu_issue", 32'(stall), 32'd0);
    step();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd6, 2'd3, 1'b0);
    @(negedge clk);
    check("alu_chain", 32'(stall), 32'd0);
    step();

    // Back-to-back div, then mfhi-style reader of the second div's dest
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd12, 2'd2, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd13, 2'd2, 1'b0);
    #1;
    check("md_busy_after_div", 32'(md_busy), 32'd1);
    count_stalls(n);
    check("div_div_stalls", 32'(n), 32'd8);
    check("md_free_at_issue", 32'(md_busy), 32'd0);
    step();
    drive(1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 1'b1, 5'd14, 2'd0, 1'b0);
    count_stalls(n);
    check("mfhi_stalls", 32'(n), 32'd8);
    step();

    // WAW: ALU write to $9 two cycles behind a div writing $9
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 2'd2, 1'b0);
    step();
    idle();
    step();
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 2'd0, 1'b0);
    count_stalls(n);
    check("waw_stalls", 32'(n), 32'd6);
    step();
    drive(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
    @(negedge clk);
    check("waw_reader_free", 32'(stall), 32'd0);
    step();

    // WAW boundary: load write stalls only while cnt > LOAD_LAT
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 2'd2, 1'b0);
    step();
    idle();
    repeat (4) step();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 2'd1, 1'b0);
    @(negedge clk);
    check("waw_cnt4_load", 32'(stall), 32'd1);
    step();
    @(negedge clk);
    check("waw_cnt3_load", 32'(stall), 32'd0);
    step();

    // Flush: squashed lw to $20 must not issue; $3 keeps counting down
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 2'd1, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd20, 2'd1, 1'b1);
    @(negedge clk);
    check("flush_no_stall", 32'(stall), 32'd0);
    step();
    drive(1'b1, 5'd20, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
    #2;
    check("flushed_not_issued", 32'(stall), 32'd0);
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
    count_stalls(n);
    check("flush_decrement", 32'(n), 32'd2);
    step();

    // Register 0 is never tracked
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 2'd1, 1'b0);
    @(negedge clk);
    check("lw_r0_issue", 32'(stall), 32'd0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
    @(negedge clk);
    check("r0_reader", 32'(stall), 32'd0);
    step();

    // id_valid = 0 never stalls, but the counter still decays
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd15, 2'd1, 1'b0);
    step();
    drive(1'b0, 5'd15, 5'd15, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
    @(negedge clk);
    check("invalid_no_stall", 32'(stall), 32'd0);
    step();
    drive(1'b1, 5'd15, 5'd15, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
    count_stalls(n);
    check("invalid_decrement", 32'(n), 32'd2);
    step();

    // Reset mid-operation
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 2'd2, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 2'd1, 1'b0);
    step();
    idle();
    step();
    step();
    check("pre_rst_md_busy", 32'(md_busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_rst_md_busy", 32'(md_busy), 32'd0);
    check("post_rst_stall_cnt", stall_cnt, 32'd0);
    drive(1'b1, 5'd4, 5'd7, 1'b1, 1'b1, 1'b1, 5'd16, 2'd2, 1'b0);
    @(negedge clk);
    check("post_rst_reader", 32'(stall), 32'd0);
    step();
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
